// File: rtl/tr_pkg.sv
// Shared types and constants for the ALU time-redundancy controller.
// The optional fault-injection ports are enabled with TR_FAULT_INJECT_EN.
package tr_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned CNT_W_DEF  = 8;

    // Index of the ALU run being observed in the current cycle
    localparam logic [1:0] RUN_1 = 2'd1;
    localparam logic [1:0] RUN_2 = 2'd2;
    localparam logic [1:0] RUN_3 = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_VOTE  = 2'd2
    } state_e;

endpackage

// File: rtl/alu_time_redundancy_ctrl_if.sv
// Execute-stage bus between the pipeline and the time-redundancy controller.
// TR_FAULT_INJECT_EN adds the fault-injection inputs.
interface alu_time_redundancy_ctrl_if
    import tr_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
);

    logic              ExecValid;
    logic [DATA_W-1:0] ALU_Result_In;
    logic              ALU_Busy_Stall;
    logic [DATA_W-1:0] ALU_Result_Out;
    logic              Result_Valid;
    logic              ErrCorrected;
    logic              ErrUncorrectable;
    logic [CNT_W-1:0]  ErrCount;
`ifdef TR_FAULT_INJECT_EN
    logic [DATA_W-1:0] FaultInj;
    logic [1:0]        FaultInjRun;

    modport master (
        output ExecValid, ALU_Result_In, FaultInj, FaultInjRun,
        input  ALU_Busy_Stall, ALU_Result_Out, Result_Valid,
               ErrCorrected, ErrUncorrectable, ErrCount
    );
    modport slave (
        input  ExecValid, ALU_Result_In, FaultInj, FaultInjRun,
        output ALU_Busy_Stall, ALU_Result_Out, Result_Valid,
               ErrCorrected, ErrUncorrectable, ErrCount
    );
`else
    modport master (
        output ExecValid, ALU_Result_In,
        input  ALU_Busy_Stall, ALU_Result_Out, Result_Valid,
               ErrCorrected, ErrUncorrectable, ErrCount
    );
    modport slave (
        input  ExecValid, ALU_Result_In,
        output ALU_Busy_Stall, ALU_Result_Out, Result_Valid,
               ErrCorrected, ErrUncorrectable, ErrCount
    );
`endif

endinterface

// File: rtl/tr_voter3.sv
// Combinational three-way majority voter with error classification.
module tr_voter3 #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [DATA_W-1:0] c_i,
    output logic [DATA_W-1:0] y_o,
    output logic              corrected_o,
    output logic              uncorrectable_o
);

    // Pick the value backed by two runs; with no majority fall back to the first run
    always_comb begin
        y_o             = a_i;
        corrected_o     = 1'b0;
        uncorrectable_o = 1'b0;
        if (a_i == b_i) begin
            y_o = a_i;
        end else if (c_i == a_i) begin
            y_o         = a_i;
            corrected_o = 1'b1;
        end else if (c_i == b_i) begin
            y_o         = b_i;
            corrected_o = 1'b1;
        end else begin
            uncorrectable_o = 1'b1;
        end
    end

endmodule

// File: rtl/alu_time_redundancy_ctrl.sv
// Time-redundancy controller: runs each ALU op twice on the shared ALU while
// F/D are frozen, and adds a voted third run when the first two disagree.
// Outputs are combinational so E/M captures the result as the stall drops.
// TR_FAULT_INJECT_EN enables per-run XOR fault injection on the ALU input.
module alu_time_redundancy_ctrl
    import tr_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    alu_time_redundancy_ctrl_if.slave bus
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] r1_q, r1_d;
    logic [DATA_W-1:0] r2_q, r2_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [DATA_W-1:0] alu_c;
    logic [DATA_W-1:0] vote_y_c;
    logic              vote_corr_c;
    logic              vote_unc_c;
    logic              busy_c;
    logic              valid_c;
    logic [DATA_W-1:0] out_c;
    logic              corr_c;
    logic              unc_c;

`ifdef TR_FAULT_INJECT_EN
    logic [1:0] run_c;

    // Corrupt only the run selected by the bench/fault campaign
    always_comb begin
        run_c = RUN_1;
        case (state_q)
            ST_CHECK: run_c = RUN_2;
            ST_VOTE:  run_c = RUN_3;
            default:  run_c = RUN_1;
        endcase
        alu_c = bus.ALU_Result_In;
        if (bus.FaultInjRun == run_c) alu_c = bus.ALU_Result_In ^ bus.FaultInj;
    end
`else
    assign alu_c = bus.ALU_Result_In;
`endif

    tr_voter3 #(.DATA_W(DATA_W)) u_voter (
        .a_i             (r1_q),
        .b_i             (r2_q),
        .c_i             (alu_c),
        .y_o             (vote_y_c),
        .corrected_o     (vote_corr_c),
        .uncorrectable_o (vote_unc_c)
    );

    // Sequencing of the redundant runs and result selection
    always_comb begin
        state_d = state_q;
        r1_d    = r1_q;
        r2_d    = r2_q;
        busy_c  = 1'b0;
        valid_c = 1'b0;
        out_c   = '0;
        corr_c  = 1'b0;
        unc_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_c = bus.ExecValid;
                if (bus.ExecValid) begin
                    r1_d    = alu_c;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (alu_c == r1_q) begin
                    valid_c = 1'b1;
                    out_c   = r1_q;
                    state_d = ST_IDLE;
                end else begin
                    r2_d    = alu_c;
                    busy_c  = 1'b1;
                    state_d = ST_VOTE;
                end
            end
            ST_VOTE: begin
                valid_c = 1'b1;
                out_c   = vote_y_c;
                corr_c  = vote_corr_c;
                unc_c   = vote_unc_c;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Saturating count of corrected errors
    always_comb begin
        cnt_d = cnt_q;
        if (corr_c && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end

    // State, capture registers and error counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            r1_q    <= '0;
            r2_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are forced low while reset is held
    assign bus.ALU_Busy_Stall   = rst & busy_c;
    assign bus.Result_Valid     = rst & valid_c;
    assign bus.ALU_Result_Out   = rst ? out_c : '0;
    assign bus.ErrCorrected     = rst & corr_c;
    assign bus.ErrUncorrectable = rst & unc_c;
    assign bus.ErrCount         = cnt_q;

endmodule

// File: doc/alu_time_redundancy_ctrl.md
Name: alu_time_redundancy_ctrl

Overview:
- Time-redundancy controller for the execute stage.
- Re-executes each ALU operation on the shared ALU while Fetch and Decode are frozen, and compares the results.
- On a mismatch, runs a third execution and majority-votes the result.
- Drives ALU_Busy_Stall into the hazard unit, and supplies the checked result to the E/M pipeline register.

Parameters:
- DATA_W, 32, ALU result width.
- CNT_W, 8, width of the saturating corrected-error counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- ExecValid  in  1  ALU-type instruction present in E; already qualified by flush, so a bubble gives 0.
- ALU_Result_In  in  DATA_W  combinational ALU output; operands are held stable while stalled.
- ALU_Busy_Stall  out  1  freezes F/D; the E stage holds its operands.
- ALU_Result_Out  out  DATA_W  checked/voted result, valid when Result_Valid=1.
- Result_Valid  out  1  result is final this cycle; E/M may capture it.
- ErrCorrected  out  1  one-cycle pulse: mismatch resolved by majority.
- ErrUncorrectable  out  1  one-cycle pulse: all three runs differ.
- ErrCount  out  CNT_W  saturating count of ErrCorrected events.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; r1 and r2 capture registers = 0; ErrCount=0. All outputs are 0 while reset is asserted. Reset mid-operation abandons the op; no result or error pulse is produced.
- States: IDLE, CHECK, VOTE. Encoding is in the package.
- IDLE:
  - ALU_Busy_Stall = ExecValid (combinational, same cycle).
  - If ExecValid: r1 <= ALU_Result_In, go to CHECK.
  - Result_Valid = 0.
- CHECK (run 2):
  - If ALU_Result_In == r1: Result_Valid=1, ALU_Result_Out=r1, ALU_Busy_Stall=0, go to IDLE.
  - Else: r2 <= ALU_Result_In, ALU_Busy_Stall=1, Result_Valid=0, go to VOTE.
- VOTE (run 3, r3 = ALU_Result_In):
  - If r3==r1, output r1. Else if r3==r2, output r2. Else output r1 and pulse ErrUncorrectable.
  - ErrCorrected=1 whenever r3 matches r1 or r2.
  - Result_Valid=1, ALU_Busy_Stall=0, go to IDLE.
- Latency: 2 cycles fault-free, 3 cycles on mismatch. The stall lasts 1 or 2 cycles respectively.
- Back-to-back ops: a new ExecValid is only sampled in IDLE. The cycle after Result_Valid, the next instruction is in E and is handled from IDLE with no idle gap.
- ALU_Result_Out is 0 whenever Result_Valid=0.
- ErrCount increments on ErrCorrected and saturates at 2^CNT_W-1 (no wrap). Uncorrectable events do not count.
- All outputs are combinational from state, the capture registers and ALU_Result_In. No register sits on the result path; E/M captures the result in the cycle the stall deasserts.
- Hazard-unit interplay: ALU_Busy_Stall high suppresses FlushE. A load-use stall coexisting with busy needs no special handling here.

Optional Feature:
- TR_FAULT_INJECT_EN defined:
  - Adds input FaultInj (DATA_W) and input FaultInjRun (2 bits: 1, 2 or 3).
  - FaultInj is XORed into ALU_Result_In for the selected run only. Used by the bench and the fault campaign.
- TR_FAULT_INJECT_EN undefined: these ports do not exist and there is no XOR logic.

Decomposition:
- Package tr_pkg:
  - state enum (IDLE/CHECK/VOTE).
  - DATA_W and CNT_W defaults.
  - run-index constants used by fault injection.
- Sub-module tr_voter3: purely combinational 3-input majority. Outputs the voted value plus corrected/uncorrectable flags. It is instantiated in VOTE.

Test Plan:
- Fault-free: ExecValid=1, ALU=0x0000_1234 held → busy high 1 cycle; next cycle Result_Valid=1, Out=0x1234, no error flags, ErrCount=0.
- Run-2 fault: runs give 0x10, 0x11, 0x10 → busy 2 cycles; VOTE outputs 0x10, ErrCorrected pulse, ErrCount=1.
- Run-1 fault: runs give 0x5, 0x4, 0x4 → Out=0x4, ErrCorrected=1.
- Triple mismatch: runs give 0x1, 0x2, 0x3 → Out=0x1, ErrUncorrectable=1, ErrCount unchanged.
- Back-to-back: two clean ops on consecutive eligible cycles → Result_Valid in cycles 2 and 4, busy pattern 1,0,1,0. With CNT_W=2 and 5 corrected errors, ErrCount stops at 3.
- Reset in VOTE: drive rst=0 mid-VOTE → outputs 0 immediately, state IDLE, ErrCount=0, no pulse after release.
